// File: rtl/ddr3_wr_ctrl.sv
// Write-side DMA stage: drains 24-bit pixels from the video burst FIFO and issues
// fixed-length Avalon-MM burst writes into a linear, per-frame wrapping frame buffer.
module ddr3_wr_ctrl #(
    parameter int BURST_LEN    = 64,
    parameter int ADDR_W       = 25,
    parameter int AVL_DW       = 32,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_BURSTS = 12000
) (
    input  logic                  afi_clk,
    input  logic                  rst,
    input  logic                  init_done,
    input  logic                  frame_sync,
    input  logic [7:0]            rd_usedw,
    input  logic [23:0]           fifo_q,
    output logic                  rd_req,
    input  logic                  avl_ready,
    output logic                  avl_write_req,
    output logic                  avl_burstbegin,
    output logic [ADDR_W-1:0]     avl_addr,
    output logic [7:0]            avl_size,
    output logic [AVL_DW-1:0]     avl_wdata,
    output logic [AVL_DW/8-1:0]   avl_be,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                IDX_W    = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [7:0]        LEN8     = 8'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BURSTS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             sync_pend;
    logic [7:0]       to_fetch;
    logic [7:0]       to_send;
    logic [23:0]      hold [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic             first_beat;
    logic             accept;

    // Fetch is throttled so buffered plus in-flight words never exceed the two slots.
    assign rd_req         = (state == BURST) && (to_fetch != 8'd0) &&
                            ((count + {1'b0, inflight}) < 2'd2);
    assign avl_write_req  = (state == BURST) && (count != 2'd0);
    assign accept         = avl_write_req && avl_ready;
    assign avl_burstbegin = avl_write_req && first_beat;
    assign avl_wdata      = AVL_DW'(hold[rd_ptr]);
    assign avl_size       = LEN8;
    assign busy           = (state == BURST);

    always_ff @(posedge afi_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sync_pend  <= 1'b0;
            to_fetch   <= '0;
            to_send    <= '0;
            // NOTE: the two holding slots are reset because the head drives avl_wdata,
            // which must read zero while in reset.
            hold[0]    <= '0;
            hold[1]    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            inflight   <= 1'b0;
            first_beat <= 1'b0;
            avl_addr   <= BASE_A;
            avl_be     <= '0;
            frame_done <= 1'b0;
        end else begin
            avl_be     <= '1;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_pend) begin
                        idx       <= '0;
                        sync_pend <= 1'b0;
                    end else if (init_done && (rd_usedw >= LEN8)) begin
                        state      <= BURST;
                        avl_addr   <= BASE_A + ADDR_W'(idx) * STRIDE;
                        to_fetch   <= LEN8;
                        to_send    <= LEN8;
                        first_beat <= 1'b1;
                    end
                end
                BURST: begin
                    inflight <= rd_req;
                    if (rd_req) to_fetch <= to_fetch - 8'd1;
                    if (inflight) begin
                        hold[wr_ptr] <= fifo_q;
                        wr_ptr       <= ~wr_ptr;
                    end
                    count <= count + {1'b0, inflight} - {1'b0, accept};
                    if (accept) begin
                        rd_ptr     <= ~rd_ptr;
                        to_send    <= to_send - 8'd1;
                        first_beat <= 1'b0;
                        if (to_send == 8'd1) begin
                            state <= IDLE;
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // NOTE: placed after the case so a new frame_sync wins over the IDLE clear
            // (the last non-blocking assignment to a register in a cycle takes effect).
            if (frame_sync) sync_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_wr_ctrl.sv
// Self-checking bench for ddr3_wr_ctrl: table of burst vectors plus hand-written
// sequences for the input-threshold, frame_sync and mid-burst reset cases.
module tb_ddr3_wr_ctrl;

    localparam int BL     = 64;
    localparam int ADDR_W = 25;
    localparam int DW     = 32;
    localparam int FB     = 3;

    logic              afi_clk;
    logic              rst;
    logic              init_done;
    logic              frame_sync;
    logic [7:0]        rd_usedw;
    logic [23:0]       fifo_q;
    logic              rd_req;
    logic              avl_ready;
    logic              avl_write_req;
    logic              avl_burstbegin;
    logic [ADDR_W-1:0] avl_addr;
    logic [7:0]        avl_size;
    logic [DW-1:0]     avl_wdata;
    logic [DW/8-1:0]   avl_be;
    logic              busy;
    logic              frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    ddr3_wr_ctrl #(
        .BURST_LEN   (BL),
        .ADDR_W      (ADDR_W),
        .AVL_DW      (DW),
        .BASE_ADDR   (0),
        .FRAME_BURSTS(FB)
    ) dut (
        .afi_clk       (afi_clk),
        .rst           (rst),
        .init_done     (init_done),
        .frame_sync    (frame_sync),
        .rd_usedw      (rd_usedw),
        .fifo_q        (fifo_q),
        .rd_req        (rd_req),
        .avl_ready     (avl_ready),
        .avl_write_req (avl_write_req),
        .avl_burstbegin(avl_burstbegin),
        .avl_addr      (avl_addr),
        .avl_size      (avl_size),
        .avl_wdata     (avl_wdata),
        .avl_be        (avl_be),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial afi_clk = 1'b0;
    always #5 afi_clk = ~afi_clk;

    // FIFO model in normal mode: the word requested at one edge appears after that edge.
    logic pend = 1'b0;
    int   pix  = 0;
    always @(negedge afi_clk) pend = rd_req;
    always @(posedge afi_clk) begin
        #1;
        if (pend) begin
            fifo_q = 24'(pix);
            pix++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] ready_pat;
        int         exp_addr;
        int         exp_first;
        int         exp_fd;
        string      name;
    } vec_t;

    vec_t vecs [4];

    // Watches one burst at negedges. sync_at pulses frame_sync after that many
    // accepted beats; stop_at returns early (no final checks) after that many beats.
    task automatic run_burst(input logic [3:0] pat, input int exp_addr, input int exp_first,
                             input int exp_fd, input int sync_at, input int stop_at,
                             input string tag);
        int cyc = 0, acc = 0, fetched = 0, lat = -1, fd = 0;
        int stab_e = 0, bb_e = 0, out_e = 0, data_e = 0, addr_e = 0, be_e = 0;
        logic prev_wait = 1'b0;
        logic [DW-1:0] prev_wdata = '0;
        logic [ADDR_W-1:0] prev_addr = '0;
        while (acc < BL && cyc < 1000) begin
            @(negedge afi_clk);
            cyc++;
            frame_sync = 1'b0;
            avl_ready  = pat[cyc[1:0]];
            if (busy && lat < 0) lat = cyc;
            if (frame_done) fd++;
            if (prev_wait && (!avl_write_req || avl_wdata !== prev_wdata || avl_addr !== prev_addr))
                stab_e++;
            if (avl_burstbegin !== (avl_write_req && acc == 0)) bb_e++;
            if (rd_req) begin
                fetched++;
                if (!busy || (fetched - acc) > 2) out_e++;
            end
            prev_wait  = avl_write_req && !avl_ready;
            prev_wdata = avl_wdata;
            prev_addr  = avl_addr;
            if (avl_write_req && avl_ready) begin
                if (avl_wdata !== 32'(24'(exp_first + acc))) data_e++;
                if (avl_addr !== ADDR_W'(exp_addr)) addr_e++;
                if (avl_be !== 4'hF) be_e++;
                acc++;
                if (acc == sync_at) frame_sync = 1'b1;
                if (acc == stop_at) return;
            end
        end
        @(negedge afi_clk);
        frame_sync = 1'b0;
        if (frame_done) fd++;
        if (rd_req) fetched++;
        check({tag, "_beats"},      acc, BL);
        check({tag, "_rd_reqs"},    fetched, BL);
        check({tag, "_data_errs"},  data_e, 0);
        check({tag, "_addr_errs"},  addr_e, 0);
        check({tag, "_be_errs"},    be_e, 0);
        check({tag, "_hold_errs"},  stab_e, 0);
        check({tag, "_bb_errs"},    bb_e, 0);
        check({tag, "_fetch_errs"}, out_e, 0);
        check({tag, "_start_lat"},  (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        check({tag, "_fd_count"},   fd, exp_fd);
        check({tag, "_fd_now"},     frame_done, exp_fd);
        check({tag, "_busy_end"},   busy, 0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{4'b1111,   0,   0, 0, "b0_ready"};
        vecs[1] = '{4'b1001,  64,  64, 0, "b1_toggle"};
        vecs[2] = '{4'b1111, 128, 128, 1, "b2_last"};
        vecs[3] = '{4'b0101,   0, 192, 0, "b3_wrap"};

        rst        = 1'b1;
        init_done  = 1'b0;
        frame_sync = 1'b0;
        rd_usedw   = 8'd0;
        avl_ready  = 1'b0;
        fifo_q     = 24'd0;
        repeat (3) @(negedge afi_clk);
        check("rst_write_req", avl_write_req, 0);
        check("rst_burstbegin", avl_burstbegin, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_wdata", avl_wdata, 0);
        check("rst_addr", avl_addr, 0);
        check("rst_be", avl_be, 0);
        check("rst_size", avl_size, BL);

        // Calibration not done: full FIFO must not start a burst.
        rst      = 1'b0;
        rd_usedw = 8'd64;
        cnt = 0;
        repeat (20) begin
            @(negedge afi_clk);
            if (busy || rd_req || avl_write_req) cnt++;
        end
        check("no_init_activity", cnt, 0);

        init_done = 1'b1;
        for (int i = 0; i < 4; i++)
            run_burst(vecs[i].ready_pat, vecs[i].exp_addr, vecs[i].exp_first,
                      vecs[i].exp_fd, -1, -1, vecs[i].name);

        // One word short of a burst: nothing may happen.
        rd_usedw = 8'd63;
        cnt = 0;
        repeat (100) begin
            @(negedge afi_clk);
            if (busy || rd_req || avl_write_req) cnt++;
        end
        check("usedw63_activity", cnt, 0);
        rd_usedw = 8'd64;

        // frame_sync during burst idx 1: burst completes, next burst restarts at base.
        run_burst(4'b1111, 64, 256, 0, 10, -1, "sync_burst");
        run_burst(4'b1111, 0, 320, 0, -1, -1, "after_sync");

        // Reset mid-burst: outputs clear before the next clock edge.
        run_burst(4'b1111, 64, 384, 0, -1, 30, "pre_reset");
        #2 rst = 1'b1;
        #1;
        check("mid_rst_write_req", avl_write_req, 0);
        check("mid_rst_burstbegin", avl_burstbegin, 0);
        check("mid_rst_rd_req", rd_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wdata", avl_wdata, 0);
        check("mid_rst_addr", avl_addr, 0);
        check("mid_rst_be", avl_be, 0);
        repeat (2) @(negedge afi_clk);
        pix = 0;
        rst = 1'b0;
        run_burst(4'b1111, 0, 0, 0, -1, -1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_ctrl.md
Name: ddr3_wr_ctrl

Overview:
- Write-side DMA stage on the DDR3 controller's afi_clk domain.
- Drains 24-bit RGB pixels from the video dual-clock burst FIFO (read port: rd_req, q, rd_usedw).
- Issues fixed-length Avalon-MM burst writes to the DDR3 controller local interface.
- Bursts go to a linear frame buffer whose address wraps once per frame.

Parameters:
- BURST_LEN, 64: beats per Avalon burst; range 1..255, limited by the 8-bit rd_usedw.
- ADDR_W, 25: Avalon word-address width.
- AVL_DW, 32: Avalon data width; must be at least 24.
- BASE_ADDR, 0: frame buffer start word address.
- FRAME_BURSTS, 12000: bursts per frame (800x960 pixels / 64).

Ports:
- afi_clk  in  1  Single clock for all logic, including the FIFO read port.
- rst  in  1  Asynchronous active-high reset.
- init_done  in  1  DDR3 calibration complete; no burst starts while low.
- frame_sync  in  1  One-cycle pulse, already synchronous to afi_clk: new frame started, FIFO cleared.
- rd_usedw  in  8  FIFO read-side fill level.
- fifo_q  in  24  FIFO read data; valid exactly 1 cycle after rd_req (normal mode, not show-ahead).
- rd_req  out  1  FIFO read request.
- avl_ready  in  1  Controller accepts the current beat.
- avl_write_req  out  1  Write beat valid.
- avl_burstbegin  out  1  Marks the first beat of a burst.
- avl_addr  out  ADDR_W  Burst start word address.
- avl_size  out  8  Burst length, constant BURST_LEN.
- avl_wdata  out  AVL_DW  Write data: zero-extended fifo_q.
- avl_be  out  AVL_DW/8  Byte enables, all ones.
- busy  out  1  High while in BURST state.
- frame_done  out  1  One-cycle pulse when the last burst of a frame completes.

Behaviour:
Reset (rst high, async):
- State=IDLE; burst index=0; sync_pend=0.
- Holding buffer empty; in-flight read=0.
- All outputs 0, except avl_addr=BASE_ADDR and avl_size=BURST_LEN.

FSM states: IDLE, BURST.

IDLE:
- If sync_pend=1: set burst index to 0, clear sync_pend, stay in IDLE for that cycle.
- Otherwise, if init_done=1 and rd_usedw >= BURST_LEN: go to BURST.
  - Latch avl_addr = BASE_ADDR + idx*BURST_LEN.
  - beats_to_fetch = BURST_LEN; beats_to_send = BURST_LEN.

BURST, fetch side:
- 2-entry holding buffer.
- rd_req=1 when beats_to_fetch > 0 and (occupancy + in-flight) < 2.
- fifo_q is written into the buffer on the cycle after rd_req.
- rd_req is never asserted outside BURST and never more than BURST_LEN times per burst.

BURST, send side:
- avl_write_req = buffer non-empty; avl_wdata = buffer head.
- A beat is accepted when avl_write_req && avl_ready; the head pops and beats_to_send decrements.
- If avl_ready=0, write_req, wdata and addr hold stable. Fetch continues only until the buffer is full.
- avl_burstbegin=1 with the first beat and held until that beat is accepted. It is 0 on all later beats.
- A simultaneous push and pop on the buffer is legal; occupancy is unchanged.

Last beat accepted:
- Return to IDLE the next cycle; busy drops.
- If idx = FRAME_BURSTS-1: idx wraps to 0 and frame_done pulses 1 cycle.
- Otherwise idx increments.
- Back-to-back bursts cost at least 1 IDLE cycle.

frame_sync:
- Sets sync_pend in any state.
- A burst in progress always completes. Data after the FIFO clear is undefined; this is accepted.
- The index reset takes effect in the next IDLE, before any new burst starts.
- frame_sync coincident with frame_done: the index ends at 0 and frame_done still pulses.

init_done dropping mid-burst: ignored until the burst ends; it then blocks new bursts.

rd_usedw is only sampled in IDLE. Underflow cannot occur because the burst starts only once BURST_LEN words are present.

Width rules: avl_wdata = {(AVL_DW-24) zeros, pixel}. The address adder is ADDR_W wide; overflow beyond ADDR_W truncates.

Test Plan:
1. Reset, then init_done=1, rd_usedw=64, avl_ready=1 constant -> exactly 64 rd_req. First write_req with burstbegin=1, addr=0. 64 accepted beats carrying FIFO data 0..63 in order. Then busy=0.
2. rd_usedw=63 held for 100 cycles -> no rd_req, no write_req. Raise to 64 -> burst starts within 2 cycles.
3. avl_ready toggles 1,0,0,1,... during a burst -> wdata/addr stable while ready=0. Never more than 2 outstanding fetches. Data order intact, exactly 64 beats. burstbegin is 1 only until the first acceptance.
4. FRAME_BURSTS=3, continuous data -> addrs 0,64,128,0. frame_done pulses once, after the third burst.
5. frame_sync pulsed at beat 10 of burst idx 1 (addr 64) -> burst finishes all 64 beats. Next burst addr=0.
6. rst asserted mid-burst at beat 30 -> outputs 0 immediately (async). After release, the next burst uses addr=BASE_ADDR with burstbegin=1.
